shift_deser_framer: RTL and testbench
=====================================

// Module: shift_deser_framer
// PURPOSE
// - Downstream consumer of the left-shift register's serial output: collects MSB-first bits into WIDTH-bit words.
// - Delivers each word on a valid/ready interface through a 2-entry output FIFO.
// - Flags framing faults and dropped words so later stages never see partial data.
// PARAMETERS
// - WIDTH  default 4  bits per word (2..32)
// - DEPTH  fixed 2    output FIFO entries (localparam, not overridable)
// PORTS
// - clk        in   1      single clock, all logic on posedge
// - rst_n      in   1      asynchronous, active-low reset
// - bit_in     in   1      serial data bit, MSB of word first
// - bit_vld    in   1      bit_in valid this cycle
// - sof        in   1      start-of-frame; qualified by bit_vld, marks the word's MSB
// - word_out   out  WIDTH  assembled word at FIFO head
// - word_vld   out  1      FIFO not empty
// - word_rdy   in   1      consumer accepts word_out when word_vld & word_rdy
// - frame_err  out  1      one-cycle pulse on framing/parity fault
// - ovf        out  1      sticky: word dropped because FIFO full; cleared only by reset
// BEHAVIOUR
// - Clock/reset: one clock (clk); reset rst_n is asynchronous, active-low.
// - Reset: state=IDLE, bit count=0, shift reg=0, FIFO empty; word_out=0, word_vld=0, frame_err=0, ovf=0.
// - FSM states: IDLE, SHIFT, PAR (PAR exists only with PARITY_CHECK_EN).
//   - IDLE: bit_vld & sof -> load bit, cnt=1, go SHIFT. bit_vld & !sof -> bit discarded, no error.
//   - SHIFT: each bit_vld shifts left (sr <= {sr[WIDTH-2:0], bit_in}), cnt++.
//     - At cnt==WIDTH: go PAR, or push word and go IDLE (no PAR).
//   - sof with bit_vld while in SHIFT or PAR: pulse frame_err, drop partial word, restart as new frame (cnt=1, SHIFT).
//   - Cycles without bit_vld: state and count hold; no timeout.
// - Latency: word is visible on word_out/word_vld the cycle after its last bit (or parity bit) is sampled.
// - FIFO:
//   - Push and pop in the same cycle are both honoured, including when full.
//   - Push when full without pop: word dropped, ovf set; FIFO contents unchanged.
//   - word_out is the head entry, holds stable while word_vld & !word_rdy.
//   - word_out reads 0 when empty.
// - Count width: $clog2(WIDTH+1); never wraps past WIDTH.
// - Reset mid-frame: partial word discarded immediately and asynchronously; no output pulse.
// CONFIGURATION
// - Macro PARITY_CHECK_EN:
//   - Defined: one even-parity bit follows each word (^word ^ parity must be 0).
//     - Mismatch: frame_err pulse, word not pushed.
//     - sof on the parity bit: treated as restart, per the sof-restart rule above.
//   - Undefined: PAR state and parity logic absent; the word is pushed directly after bit WIDTH.
// STRUCTURE
// - Package shift_deser_pkg:
//   - state enum typedef (IDLE/SHIFT/PAR)
//   - FIFO_DEPTH=2 constant
//   - cnt_width function
// - Sub-module shift_deser_fifo: 2-entry WIDTH-wide synchronous FIFO, push/pop/full/empty.
//   - Contains no framing logic.
// - Top module contains FSM, shift register, parity check and error/ovf flags.
// TESTING (WIDTH=4)
// - Basic word: bits 0,1,1,1 with sof on first, word_rdy=1 -> word_out=4'b0111, word_vld high 1 cycle after 4th bit.
// - Gapped input: same bits with bit_vld low 3 cycles between bits -> same 4'b0111, no frame_err.
// - Mid-frame restart: bits 1,0 then sof with bits 1,1,0,0 -> frame_err 1-cycle pulse at the restart cycle; single word 4'b1100.
// - Backpressure: word_rdy=0, send 3 words (A,B,C) -> A,B held in order, C dropped, ovf=1; later pops return A then B.
// - Full push+pop: FIFO full, word_rdy=1 in the cycle a new word completes -> head pops, new word stored, ovf stays 0.
// - Parity (PARITY_CHECK_EN): 0111 + parity 1 -> accepted; 0111 + parity 0 -> frame_err pulse, no word.
// - Async reset: assert rst_n low mid-frame between clock edges -> all outputs 0 immediately; next sof frame decodes cleanly.

Source files
------------

// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the serial-to-word deframer.
// Optional build macro: PARITY_CHECK_EN (enables the PAR state in shift_deser_framer).
package shift_deser_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

    // Bit counter must represent 0..w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/shift_deser_fifo.sv
// Two-entry synchronous FIFO; a push while full is accepted only if a pop happens in the same cycle.
module shift_deser_fifo
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_reg [FIFO_DEPTH];
    // Single-bit pointers are enough because the depth is fixed at two.
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == 2'(FIFO_DEPTH));
    assign empty   = (count_reg == 2'd0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop);
    assign dout    = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem_reg[wr_ptr_reg] <= din;
                wr_ptr_reg          <= ~wr_ptr_reg;
            end
            if (pop_ok) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/shift_deser_framer.sv
// Collects MSB-first serial bits into WIDTH-bit words and queues them in a 2-entry FIFO.
// Optional build macro: PARITY_CHECK_EN (one even-parity bit follows every word).
module shift_deser_framer
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_vld,
    input  logic             sof,
    output logic [WIDTH-1:0] word_out,
    output logic             word_vld,
    input  logic             word_rdy,
    output logic             frame_err,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] sr_reg, sr_next;
    logic [WIDTH-1:0] push_data;
    logic             push;
    logic             err_reg, err_next;
    logic             ovf_reg;
    logic             fifo_full;
    logic             fifo_empty;

    assign cnt_inc = cnt_reg + CW'(1);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sr_next    = sr_reg;
        push       = 1'b0;
        push_data  = {sr_reg[WIDTH-2:0], bit_in};
        err_next   = 1'b0;
        if (bit_vld) begin
            if (sof) begin
                // sof always starts a fresh word; only a frame in progress is an error.
                err_next   = (state_reg != IDLE);
                sr_next    = {{(WIDTH-1){1'b0}}, bit_in};
                cnt_next   = CW'(1);
                state_next = SHIFT;
            end else begin
                case (state_reg)
                    SHIFT: begin
                        sr_next  = {sr_reg[WIDTH-2:0], bit_in};
                        cnt_next = cnt_inc;
                        if (cnt_inc == CW'(WIDTH)) begin
`ifdef PARITY_CHECK_EN
                            state_next = PAR;
`else
                            push       = 1'b1;
                            cnt_next   = '0;
                            state_next = IDLE;
`endif
                        end
                    end
`ifdef PARITY_CHECK_EN
                    PAR: begin
                        push_data  = sr_reg;
                        push       = ~(^sr_reg ^ bit_in);
                        err_next   = ^sr_reg ^ bit_in;
                        cnt_next   = '0;
                        state_next = IDLE;
                    end
`endif
                    default: begin
                        // Bits outside a frame are silently discarded.
                        state_next = IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sr_reg    <= '0;
            err_reg   <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sr_reg    <= sr_next;
            err_reg   <= err_next;
            ovf_reg   <= ovf_reg | (push & fifo_full & ~word_rdy);
        end
    end

    shift_deser_fifo #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_data),
        .pop   (word_rdy),
        .dout  (word_out),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign word_vld  = ~fifo_empty;
    assign frame_err = err_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_shift_deser_framer.sv
// Directed self-checking bench for shift_deser_framer at WIDTH=4.
module tb_shift_deser_framer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bit_in;
    logic       bit_vld;
    logic       sof;
    logic [3:0] word_out;
    logic       word_vld;
    logic       word_rdy;
    logic       frame_err;
    logic       ovf;

    int checks = 0;
    int errors = 0;

    shift_deser_framer #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_vld   (bit_vld),
        .sof       (sof),
        .word_out  (word_out),
        .word_vld  (word_vld),
        .word_rdy  (word_rdy),
        .frame_err (frame_err),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one bit for exactly one rising edge, return 1ns after that edge.
    task automatic drive(input logic b, input logic s);
        bit_in  = b;
        bit_vld = 1'b1;
        sof     = s;
        @(posedge clk);
        #1;
        bit_vld = 1'b0;
        sof     = 1'b0;
        bit_in  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Parity bit that closes a word when the parity build is used.
    task automatic send_par(input logic [3:0] w);
`ifdef PARITY_CHECK_EN
        drive(^w, 1'b0);
`else
        if (w === 4'hx) $display("unused");
`endif
    endtask

    task automatic send_word(input logic [3:0] w);
        drive(w[3], 1'b1);
        drive(w[2], 1'b0);
        drive(w[1], 1'b0);
        drive(w[0], 1'b0);
        send_par(w);
    endtask

    initial begin
        rst_n    = 1'b0;
        bit_in   = 1'b0;
        bit_vld  = 1'b0;
        sof      = 1'b0;
        word_rdy = 1'b1;
        idle(2);
        chk("rst_word_out", 32'(word_out), 32'h0);
        chk("rst_word_vld", 32'(word_vld), 32'h0);
        chk("rst_frame_err", 32'(frame_err), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        rst_n = 1'b1;
        idle(1);

        // Basic word 0111
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        chk("basic_vld_early", 32'(word_vld), 32'h0);
        drive(1'b1, 1'b0);
        send_par(4'b0111);
        chk("basic_vld", 32'(word_vld), 32'h1);
        chk("basic_word", 32'(word_out), 32'h7);
        chk("basic_err", 32'(frame_err), 32'h0);
        $display("basic word: out=%h vld=%0d", word_out, word_vld);
        idle(1);
        chk("basic_popped", 32'(word_vld), 32'h0);

        // Gapped bits, three idle cycles between each
        drive(1'b0, 1'b1);
        idle(3);
        drive(1'b1, 1'b0);
        idle(3);
        drive(1'b1, 1'b0);
        idle(3);
        chk("gap_vld_early", 32'(word_vld), 32'h0);
        drive(1'b1, 1'b0);
        send_par(4'b0111);
        chk("gap_vld", 32'(word_vld), 32'h1);
        chk("gap_word", 32'(word_out), 32'h7);
        chk("gap_err", 32'(frame_err), 32'h0);
        $display("gapped word: out=%h vld=%0d", word_out, word_vld);
        idle(1);

        // Mid-frame restart: 1,0 then sof 1,1,0,0
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b1);
        chk("restart_err", 32'(frame_err), 32'h1);
        chk("restart_vld", 32'(word_vld), 32'h0);
        drive(1'b1, 1'b0);
        chk("restart_err_clear", 32'(frame_err), 32'h0);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        send_par(4'b1100);
        chk("restart_vld2", 32'(word_vld), 32'h1);
        chk("restart_word", 32'(word_out), 32'hC);
        $display("restart word: out=%h err=%0d", word_out, frame_err);
        idle(1);
        chk("restart_single", 32'(word_vld), 32'h0);

        // Backpressure: A, B stored, C dropped
        word_rdy = 1'b0;
        send_word(4'hA);
        chk("bp_a_vld", 32'(word_vld), 32'h1);
        chk("bp_a_word", 32'(word_out), 32'hA);
        send_word(4'h3);
        chk("bp_b_head", 32'(word_out), 32'hA);
        chk("bp_b_ovf", 32'(ovf), 32'h0);
        send_word(4'hF);
        chk("bp_c_ovf", 32'(ovf), 32'h1);
        chk("bp_c_head", 32'(word_out), 32'hA);
        idle(1);
        chk("bp_hold", 32'(word_out), 32'hA);
        word_rdy = 1'b1;
        idle(1);
        chk("bp_pop_b", 32'(word_out), 32'h3);
        chk("bp_pop_b_vld", 32'(word_vld), 32'h1);
        idle(1);
        chk("bp_empty_vld", 32'(word_vld), 32'h0);
        chk("bp_empty_word", 32'(word_out), 32'h0);
        chk("bp_ovf_sticky", 32'(ovf), 32'h1);
        $display("backpressure: ovf=%0d", ovf);

        // Async reset mid-frame with a queued word and ovf set
        word_rdy = 1'b0;
        send_word(4'h5);
        drive(1'b1, 1'b1);
        drive(1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(word_vld), 32'h0);
        chk("arst_word", 32'(word_out), 32'h0);
        chk("arst_ovf", 32'(ovf), 32'h0);
        chk("arst_err", 32'(frame_err), 32'h0);
        $display("async reset: vld=%0d ovf=%0d", word_vld, ovf);
        #1;
        rst_n = 1'b1;
        idle(1);

        // Clean frame after reset, then full push+pop
        drive(1'b0, 1'b1);
        chk("post_rst_err", 32'(frame_err), 32'h0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        send_par(4'b0110);
        chk("post_rst_word", 32'(word_out), 32'h6);
        send_word(4'h9);
        chk("full_head", 32'(word_out), 32'h6);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
`ifdef PARITY_CHECK_EN
        drive(1'b1, 1'b0);
        word_rdy = 1'b1;
        send_par(4'b0101);
`else
        word_rdy = 1'b1;
        drive(1'b1, 1'b0);
`endif
        chk("pp_head", 32'(word_out), 32'h9);
        chk("pp_ovf", 32'(ovf), 32'h0);
        idle(1);
        chk("pp_new", 32'(word_out), 32'h5);
        idle(1);
        chk("pp_empty", 32'(word_vld), 32'h0);
        chk("pp_ovf_end", 32'(ovf), 32'h0);
        $display("push+pop while full: ovf=%0d", ovf);

`ifdef PARITY_CHECK_EN
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        chk("par_wait", 32'(word_vld), 32'h0);
        drive(1'b1, 1'b0);
        chk("par_ok_word", 32'(word_out), 32'h7);
        chk("par_ok_err", 32'(frame_err), 32'h0);
        idle(1);
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        chk("par_bad_err", 32'(frame_err), 32'h1);
        chk("par_bad_vld", 32'(word_vld), 32'h0);
        $display("parity: err=%0d vld=%0d", frame_err, word_vld);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
